// File: rtl/pattern_loader_if.sv
// Parallel word bus feeding the pattern loader.
// The source drives word_in/word_valid and the loader answers with word_ready.
interface pattern_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_in, output word_valid, input word_ready);
    modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/pattern_loader.sv
// Pattern loader: collects PAT_BITS/WORD_W parallel words into a buffer, then streams
// the buffer MSB first on prgm with enable high for exactly PAT_BITS cycles.
//
// state | meaning
// IDLE  | waiting for a start pulse
// FILL  | accepting words into the buffer, first word lands in the top slot
// SHIFT | prgm = buffer MSB, enable high, buffer shifts left each cycle
// DONE  | one-cycle done pulse, then back to IDLE
module pattern_loader #(
    parameter int PAT_BITS = 256,
    parameter int WORD_W   = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic            abort,
    pattern_loader_if.slave wbus,
    output logic            prgm,
    output logic            enable,
    output logic            busy,
    output logic            done
);
    localparam int NW  = PAT_BITS / WORD_W;
    localparam int WCW = $clog2(NW) + 1;
    localparam int BCW = $clog2(PAT_BITS) + 1;
    localparam int IW  = (PAT_BITS > 1) ? $clog2(PAT_BITS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, SHIFT, DONE} state_t;

    state_t              state;
    logic [PAT_BITS-1:0] pat_buf;
    logic [WCW-1:0]      word_cnt;
    logic [BCW-1:0]      bit_cnt;
    logic [IW-1:0]       slot_lsb;

    // Word k goes to slot NW-1-k so the first word ends up holding the MSBs.
    assign slot_lsb = IW'((NW - 1 - int'(word_cnt)) * WORD_W);

    // enable is a register cleared by clr, so prgm also drops asynchronously.
    assign prgm = enable & pat_buf[PAT_BITS-1];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state           <= IDLE;
            pat_buf         <= '0;
            word_cnt        <= '0;
            bit_cnt         <= '0;
            wbus.word_ready <= 1'b0;
            enable          <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else if (abort) begin
            state           <= IDLE;
            word_cnt        <= '0;
            bit_cnt         <= '0;
            wbus.word_ready <= 1'b0;
            enable          <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= FILL;
                        word_cnt        <= '0;
                        bit_cnt         <= '0;
                        wbus.word_ready <= 1'b1;
                        busy            <= 1'b1;
                    end
                end
                FILL: begin
                    if (wbus.word_valid) begin
                        pat_buf[slot_lsb +: WORD_W] <= wbus.word_in;
                        word_cnt                    <= word_cnt + 1'b1;
                        if (word_cnt == WCW'(NW - 1)) begin
                            state           <= SHIFT;
                            wbus.word_ready <= 1'b0;
                            enable          <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    pat_buf <= {pat_buf[PAT_BITS-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == BCW'(PAT_BITS - 1)) begin
                        state  <= DONE;
                        enable <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    word_cnt <= '0;
                    bit_cnt  <= '0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader: fills, streams, stalls, aborts and async resets,
// each scenario checking the serial stream against hand-computed patterns.
module tb_pattern_loader;
    localparam int PB = 256;
    localparam int WW = 32;
    localparam int NW = PB / WW;

    logic clk, clr, start, abort;
    logic prgm, enable, busy, done;
    int   n_cmp  = 0;
    int   n_fail = 0;

    pattern_loader_if #(.WORD_W(WW)) bus ();

    pattern_loader #(.PAT_BITS(PB), .WORD_W(WW)) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .abort  (abort),
        .wbus   (bus),
        .prgm   (prgm),
        .enable (enable),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives NW words with gap[i] idle cycles before word i; counts samples that show
    // an early SHIFT or a dropped word_ready before the last word.
    task automatic send_words(input logic [WW-1:0] w [NW], input int gap [NW], output int early);
        early = 0;
        for (int i = 0; i < NW; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                bus.word_valid = 1'b0;
                tick();
                if (enable || !bus.word_ready) early++;
            end
            bus.word_in    = w[i];
            bus.word_valid = 1'b1;
            tick();
            if (i < NW - 1 && (enable || !bus.word_ready)) early++;
        end
        bus.word_valid = 1'b0;
        bus.word_in    = '0;
    endtask

    // Runs a fixed window starting right after the last accepted word (k=0) and records
    // the stream; optional disturbances are injected at given cycle indices.
    task automatic collect_stream(input int start_at, input int valid_from, input int valid_to,
                                  input int abort_at, output logic [PB-1:0] bits, output int n_en,
                                  output int n_done, output int done_at, output int n_rdy,
                                  output int n_stray);
        bits = '0; n_en = 0; n_done = 0; done_at = -1; n_rdy = 0; n_stray = 0;
        for (int k = 0; k < PB + 6; k++) begin
            if (enable) begin
                bits = {bits[PB-2:0], prgm};
                n_en++;
            end
            if (!enable && prgm) n_stray++;
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            if (bus.word_ready) n_rdy++;
            start          = (k == start_at);
            abort          = (k == abort_at);
            bus.word_valid = (k >= valid_from && k <= valid_to);
            bus.word_in    = 32'hA5A5_A5A5;
            tick();
        end
        start = 1'b0; abort = 1'b0; bus.word_valid = 1'b0; bus.word_in = '0;
    endtask

    task automatic test_reset();
        clr = 1'b0; start = 1'b0; abort = 1'b0;
        bus.word_valid = 1'b1; bus.word_in = '1;
        repeat (3) tick();
        n_cmp++;
        if ({bus.word_ready, prgm, enable, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy/prgm/en/busy/done=%b want 00000",
                     {bus.word_ready, prgm, enable, busy, done});
        end
        clr = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b0 || bus.word_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b word_ready=%b want 0 0", busy, bus.word_ready);
        end
        bus.word_valid = 1'b0;
    endtask

    task automatic test_full_load(input string tag, input logic [PB-1:0] exp,
                                  input int start_at, input int valid_from, input int valid_to);
        logic [WW-1:0]  w [NW];
        int             gap [NW];
        logic [PB-1:0]  bits;
        int early, n_en, n_done, done_at, n_rdy, n_stray;
        for (int i = 0; i < NW; i++) begin
            w[i]   = exp[PB-1-WW*i -: WW];
            gap[i] = 0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (bus.word_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s start_latency: word_ready=%b busy=%b want 1 1", tag, bus.word_ready, busy);
        end
        send_words(w, gap, early);
        collect_stream(start_at, valid_from, valid_to, -1, bits, n_en, n_done, done_at, n_rdy, n_stray);
        n_cmp++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL %s fill_early: %0d bad samples want 0", tag, early);
        end
        n_cmp++;
        if (n_en !== PB) begin
            n_fail++;
            $display("FAIL %s enable_cycles: got %0d want %0d", tag, n_en, PB);
        end
        n_cmp++;
        if (bits !== exp) begin
            n_fail++;
            $display("FAIL %s stream: got %h want %h", tag, bits, exp);
        end
        n_cmp++;
        if (n_done !== 1 || done_at !== PB) begin
            n_fail++;
            $display("FAIL %s done_pulse: count=%0d at=%0d want 1 at %0d", tag, n_done, done_at, PB);
        end
        n_cmp++;
        if (n_rdy !== 0 || n_stray !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post_state: rdy_cycles=%0d stray_prgm=%0d busy=%b want 0 0 0",
                     tag, n_rdy, n_stray, busy);
        end
    endtask

    task automatic test_stalled_fill();
        logic [WW-1:0]  w [NW];
        int             gap [NW];
        logic [PB-1:0]  bits, exp;
        int early, n_en, n_done, done_at, n_rdy, n_stray;
        w   = '{32'h8000_0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0001};
        gap = '{1, 2, 3, 1, 3, 2, 1, 3};
        exp = '0;
        exp[255] = 1'b1; exp[224] = 1'b1; exp[0] = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_words(w, gap, early);
        collect_stream(-1, -1, -2, -1, bits, n_en, n_done, done_at, n_rdy, n_stray);
        n_cmp++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL stall_early_shift: %0d bad samples want 0", early);
        end
        n_cmp++;
        if (bits !== exp || n_en !== PB) begin
            n_fail++;
            $display("FAIL stall_stream: got %h (%0d bits) want %h (%0d bits)", bits, n_en, exp, PB);
        end
        n_cmp++;
        if (n_done !== 1 || done_at !== PB) begin
            n_fail++;
            $display("FAIL stall_done: count=%0d at=%0d want 1 at %0d", n_done, done_at, PB);
        end
    endtask

    task automatic test_abort_shift();
        logic [WW-1:0]  w [NW];
        int             gap [NW];
        logic [PB-1:0]  bits, exp;
        int early, n_en, n_done, done_at, n_rdy, n_stray;
        w   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        gap = '{default: 0};
        exp = {{100{1'b1}}};
        start = 1'b1;
        tick();
        start = 1'b0;
        send_words(w, gap, early);
        collect_stream(-1, -1, -2, 99, bits, n_en, n_done, done_at, n_rdy, n_stray);
        n_cmp++;
        if (n_en !== 100 || bits !== exp) begin
            n_fail++;
            $display("FAIL abort_shift_enable: %0d cycles bits %h want 100 cycles %h", n_en, bits, exp);
        end
        n_cmp++;
        if (n_done !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_shift_no_done: done_count=%0d busy=%b want 0 0", n_done, busy);
        end
    endtask

    task automatic test_abort_fill();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || bus.word_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort_idle: busy=%b word_ready=%b want 0 0", busy, bus.word_ready);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.word_valid = 1'b1; bus.word_in = 32'hFFFF_FFFF;
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0; bus.word_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || bus.word_ready !== 1'b0 || enable !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_fill: busy=%b word_ready=%b enable=%b want 0 0 0",
                     busy, bus.word_ready, enable);
        end
        tick();
    endtask

    task automatic test_async_reset_fill();
        for (int pass = 0; pass < 1; pass++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int i = 0; i < 5; i++) begin
                bus.word_valid = 1'b1; bus.word_in = 32'hFFFF_0000;
                tick();
            end
            bus.word_valid = 1'b0;
            #3 clr = 1'b0;
            #1;
            n_cmp++;
            if ({bus.word_ready, prgm, enable, busy, done} !== 5'b0) begin
                n_fail++;
                $display("FAIL async_reset_fill: rdy/prgm/en/busy/done=%b want 00000",
                         {bus.word_ready, prgm, enable, busy, done});
            end
            #2 clr = 1'b1;
            repeat (3) tick();
            n_cmp++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL async_release_no_start: busy=%b want 0", busy);
            end
        end
    endtask

    task automatic test_async_reset_shift();
        logic [WW-1:0] w [NW];
        int            gap [NW];
        int            early;
        w   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        gap = '{default: 0};
        start = 1'b1;
        tick();
        start = 1'b0;
        send_words(w, gap, early);
        repeat (10) tick();
        n_cmp++;
        if (enable !== 1'b1 || prgm !== 1'b1) begin
            n_fail++;
            $display("FAIL shift_before_reset: enable=%b prgm=%b want 1 1", enable, prgm);
        end
        #3 clr = 1'b0;
        #1;
        n_cmp++;
        if (enable !== 1'b0 || prgm !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_shift: enable=%b prgm=%b busy=%b want 0 0 0", enable, prgm, busy);
        end
        #2 clr = 1'b1;
        tick();
    endtask

    initial begin
        bus.word_valid = 1'b0;
        bus.word_in    = '0;
        test_reset();
        test_full_load("full", {{128{1'b1}}, {128{1'b0}}}, -1, -1, -2);
        test_stalled_fill();
        test_abort_shift();
        test_full_load("after_abort", {{128{1'b1}}, {128{1'b0}}}, -1, -1, -2);
        test_abort_fill();
        test_full_load("after_fill_abort",
                       256'h01234567_89ABCDEF_FEDCBA98_76543210_0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0,
                       -1, -1, -2);
        test_full_load("ignored_inputs", {{128{1'b1}}, {128{1'b0}}}, 50, 200, PB);
        test_async_reset_fill();
        test_full_load("after_async_reset",
                       256'h01234567_89ABCDEF_FEDCBA98_76543210_0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0,
                       -1, -1, -2);
        test_async_reset_shift();
        test_full_load("after_shift_reset", {{128{1'b1}}, {128{1'b0}}}, -1, -1, -2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pattern_loader.md
PATTERN_LOADER -- requirements
Module: pattern_loader

Interface
REQ-001 Parameter PAT_BITS, default 256: pattern length in bits, shifted out serially.
REQ-002 Parameter WORD_W, default 32: width of one parallel input word; PAT_BITS SHALL be an integer multiple of WORD_W.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin loading a new pattern.
REQ-006 abort  input  1  cancels any load in progress.
REQ-007 word_in  input  WORD_W  pattern word; the first word carries pattern bits [PAT_BITS-1 : PAT_BITS-WORD_W].
REQ-008 word_valid  input  1  word_in is valid this cycle.
REQ-009 word_ready  output  1  loader accepts word_in this cycle.
REQ-010 prgm  output  1  serial pattern bit to the downstream decoder, MSB first.
REQ-011 enable  output  1  downstream decoder SHALL load prgm on each rising edge while high.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse when the full pattern has been shifted out.

Function
REQ-014 States SHALL be IDLE, FILL, SHIFT and DONE; all outputs SHALL be registered or decoded from state only, with no combinational input-to-output path.
REQ-015 IDLE -> FILL on the edge where start=1; start in any other state SHALL be ignored.
REQ-016 In FILL, word_ready SHALL be 1, and a word SHALL be accepted on each edge with word_valid=1.
REQ-017 A word accepted in FILL SHALL be written into a PAT_BITS buffer at slot (PAT_BITS/WORD_W-1-word_count); word_count SHALL then increment.
REQ-018 On acceptance of word number PAT_BITS/WORD_W (8 by default), FILL -> SHIFT, and word_ready SHALL be 0 from the next cycle.
REQ-019 Gaps (word_valid=0) in FILL SHALL stall the load with no timeout; buffer and count SHALL hold.
REQ-020 word_valid outside FILL SHALL be ignored, and the buffer SHALL be unchanged.
REQ-021 In SHIFT, enable SHALL be 1, prgm SHALL equal the buffer MSB, and the buffer SHALL shift left by 1 each cycle, inserting 0.
REQ-022 SHIFT SHALL last exactly PAT_BITS cycles, counted by a bit counter of width clog2(PAT_BITS)+1.
REQ-023 After the final bit, SHIFT -> DONE; in DONE, done=1 and enable=0 for one cycle, then DONE -> IDLE.
REQ-024 Outside SHIFT, enable and prgm SHALL both be 0.
REQ-025 Latency: start at edge t gives word_ready=1 at t+1; the last word accepted at edge u gives the first enable=1 cycle at u+1, last enable cycle at u+PAT_BITS, and done at u+PAT_BITS+1.
REQ-026 abort=1 in any state SHALL force IDLE on the next edge, clear counters, drive enable/prgm/done=0 and word_ready=0, and leave the buffer contents don't-care.
REQ-027 abort has priority over start, and over word acceptance, in the same cycle.
REQ-028 start and abort both high in IDLE SHALL leave the block in IDLE.
REQ-029 A pattern that is partially shifted when aborted SHALL NOT raise done.

Reset
REQ-030 clr=0 SHALL immediately force IDLE, buffer=0, word_count=0, bit counter=0, word_ready=0, prgm=0, enable=0, busy=0 and done=0, independent of clk.
REQ-031 Release of clr SHALL take effect at the next rising edge, and no transfer SHALL start without a fresh start pulse.
REQ-032 Reset asserted mid-FILL or mid-SHIFT SHALL behave as REQ-030, and enable SHALL fall without waiting for a clock edge.

Verification
REQ-033 Reset and idle: hold clr=0 for 3 cycles with word_valid=1 -> all outputs 0, and after release, busy=0 until start.
REQ-034 Full load: start, then words 0xFFFFFFFF x4 then 0x00000000 x4 back-to-back -> enable high exactly 256 cycles, prgm=1 for the first 128 and 0 for the last 128, and done pulses once at u+257.
REQ-035 Stalled fill: words 0x80000001, 0, 0, 0, 0, 0, 0, 0x00000001 with word_valid gaps of 1-3 cycles -> prgm=1 only at enable cycles 1, 32 and 256, with no early SHIFT entry.
REQ-036 Abort mid-SHIFT at enable cycle 100 -> enable=0 next cycle, no done pulse, busy=0, and a following full load behaves as REQ-034.
REQ-037 Async reset mid-FILL after 5 words -> outputs cleared without a clock edge, and after release, start plus 8 words yields a correct 256-bit stream.
REQ-038 Ignored inputs: start pulsed during SHIFT, and word_valid=1 during SHIFT/DONE -> stream unchanged and word_ready stays 0.
